// File: rtl/iob_ibex_axi_arb_pkg.sv
// Shared types and constants for the Ibex instruction/data to AXI4 arbiter.
package iob_ibex_axi_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_ADDR = 3'd1;
  localparam state_t ST_RD_RESP = 3'd2;
  localparam state_t ST_WR_ADDR = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int unsigned ID_INSTR = 0;
  localparam int unsigned ID_DATA  = 1;

endpackage

// File: rtl/iob_ibex_rr_arb2.sv
// Two-requester round-robin arbiter; the last accepted winner loses the next tie.
module iob_ibex_rr_arb2
  import iob_ibex_axi_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   cke_i,
  input  logic   arst_i,
  input  logic   instr_req_i,
  input  logic   data_req_i,
  input  logic   accept_i,
  output logic   valid_o,
  output owner_t winner_o
);

  owner_t prio_q;

  always_comb begin
    valid_o = instr_req_i | data_req_i;
    if (instr_req_i && data_req_i) begin
      winner_o = (prio_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
    end else if (data_req_i) begin
      winner_o = OWN_DATA;
    end else begin
      winner_o = OWN_INSTR;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      prio_q <= OWN_DATA;
    end else if (cke_i && accept_i) begin
      prio_q <= winner_o;
    end
  end

endmodule

// File: rtl/iob_ibex_axi_arb.sv
// Shares one AXI4 master between the Ibex fetch and LSU ports, one transaction in flight.
module iob_ibex_axi_arb
  import iob_ibex_axi_arb_pkg::*;
#(
  parameter int unsigned AXI_ID_W = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_W-1:0]     instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_W-1:0]     instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [DATA_W/8-1:0]   data_be_i,
  input  logic [ADDR_W-1:0]     data_addr_i,
  input  logic [DATA_W-1:0]     data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_W-1:0]     data_rdata_o,
  output logic                  data_err_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [AXI_ID_W-1:0]   awid_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i,
  input  logic [AXI_ID_W-1:0]   bid_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_W-1:0]     araddr_o,
  output logic [AXI_ID_W-1:0]   arid_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic [AXI_ID_W-1:0]   rid_i,
  input  logic                  rlast_i,
  output logic                  idle_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  owner_t              owner_q, winner;
  logic                arb_valid, accept;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   be_q;
  logic                aw_done_q, w_done_q;
  logic                aw_hs, w_hs, wr_addr_done, gnt;
  logic                rd_resp, wr_resp, resp, err;
  logic [DATA_W-1:0]   rdata;

  // Routing is by owner_q alone, so response IDs and rlast carry no information.
  logic unused_ok;
  assign unused_ok = ^{rid_i, bid_i, rlast_i};

  iob_ibex_rr_arb2 u_rr_arb (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .arst_i      (arst_i),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .accept_i    (accept),
    .valid_o     (arb_valid),
    .winner_o    (winner)
  );

  assign accept = cke_i & (state_q == ST_IDLE) & arb_valid;

  always_comb begin
    arvalid_o    = cke_i & (state_q == ST_RD_ADDR);
    awvalid_o    = cke_i & (state_q == ST_WR_ADDR) & ~aw_done_q;
    wvalid_o     = cke_i & (state_q == ST_WR_ADDR) & ~w_done_q;
    rready_o     = cke_i & (state_q == ST_RD_RESP);
    bready_o     = cke_i & (state_q == ST_WR_RESP);
    aw_hs        = awvalid_o & awready_i;
    w_hs         = wvalid_o & wready_i;
    wr_addr_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);
    gnt          = (arvalid_o & arready_i) |
                   (cke_i & (state_q == ST_WR_ADDR) & wr_addr_done);
    rd_resp      = rready_o & rvalid_i;
    wr_resp      = bready_o & bvalid_i;
    resp         = rd_resp | wr_resp;
    err          = (rd_resp & (|rresp_i)) | (wr_resp & (|bresp_i));
    rdata        = rd_resp ? rdata_i : '0;
  end

  assign wlast_o  = wvalid_o;
  assign awaddr_o = addr_q;
  assign araddr_o = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = be_q;
  assign awid_o   = AXI_ID_W'(ID_DATA);
  assign arid_o   = (owner_q == OWN_DATA) ? AXI_ID_W'(ID_DATA) : AXI_ID_W'(ID_INSTR);
  assign idle_o   = (state_q == ST_IDLE);

  assign instr_gnt_o    = gnt & (owner_q == OWN_INSTR);
  assign instr_rvalid_o = resp & (owner_q == OWN_INSTR);
  assign instr_err_o    = err & (owner_q == OWN_INSTR);
  assign instr_rdata_o  = (owner_q == OWN_INSTR) ? rdata : '0;
  assign data_gnt_o     = gnt & (owner_q == OWN_DATA);
  assign data_rvalid_o  = resp & (owner_q == OWN_DATA);
  assign data_err_o     = err & (owner_q == OWN_DATA);
  assign data_rdata_o   = (owner_q == OWN_DATA) ? rdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (winner == OWN_DATA && data_we_i) ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (gnt) state_d = ST_RD_RESP;
      ST_WR_ADDR: if (gnt) state_d = ST_WR_RESP;
      ST_RD_RESP: if (rd_resp) state_d = ST_IDLE;
      ST_WR_RESP: if (wr_resp) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_INSTR;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= winner;
        if (winner == OWN_DATA) begin
          addr_q  <= data_addr_i;
          wdata_q <= data_wdata_i;
          be_q    <= data_be_i;
        end else begin
          addr_q  <= instr_addr_i;
          wdata_q <= '0;
          be_q    <= '0;
        end
      end
      // AW and W may complete in different cycles; remember each until both are done.
      if (gnt) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

endmodule
